uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader_if.sv | 24 ++
 rtl/uart_boot_loader.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Avalon-MM write-master bundle between the UART boot loader and the memory interconnect.
interface uart_boot_loader_if;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_writedata,
    output avm_byteenable,
    output avm_write,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_write,
    output avm_waitrequest
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a framed, checksummed image and writes it word by word
// over Avalon-MM, keeping the CPU in reset until the image is loaded and verified.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 16384
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx,
  uart_boot_loader_if.master        avm,
  output logic                      cpu_hold,
  output logic                      boot_done,
  output logic                      boot_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_HDR, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} boot_state_t;

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] MAX_LEN  = 32'(MAX_WORDS);

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    csum_add = sum + data;
  endfunction

  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t   rx_state_r, rx_state_s;
  logic [15:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]  rx_bit_r, rx_bit_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic        byte_valid_s, frame_err_s;

  boot_state_t state_r, state_s;
  logic [1:0]  byte_cnt_r;
  logic [31:0] len_r;
  logic [23:0] asm_r;
  logic [31:0] word_idx_r;
  logic [7:0]  sum_r;
  logic        csum_ok_r;

  logic [31:0] len_full_s, word_s;
  logic        word_done_s, overrun_s, load_word_s, pending_s, sum_match_s;

  logic        avm_write_r;
  logic [31:0] avm_address_r, avm_writedata_r;
  logic        cpu_hold_r, boot_done_r, boot_err_r;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver bit-timing next-state logic
  always_comb begin
    rx_state_s   = rx_state_r;
    rx_cnt_s     = rx_cnt_r + 16'd1;
    rx_bit_s     = rx_bit_r;
    rx_shift_s   = rx_shift_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = 16'd0;
        if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START;
        else                         rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_CNT) begin
          rx_cnt_s = 16'd0;
          rx_bit_s = 3'd0;
          // a start bit that is high again at mid-bit was only a glitch
          if (rx_sync_r) rx_state_s = RX_IDLE;
          else           rx_state_s = RX_DATA;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_CNT) begin
          rx_cnt_s   = 16'd0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_s = RX_STOP;
          else                  rx_state_s = RX_DATA;
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_CNT) begin
          rx_state_s = RX_IDLE;
          if (rx_sync_r) byte_valid_s = 1'b1;
          else           frame_err_s  = 1'b1;
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
    end
  end

  assign pending_s   = avm_write_r & avm.avm_waitrequest;
  assign word_done_s = byte_valid_s & (state_r == ST_DATA) & (byte_cnt_r == 2'd3);
  assign overrun_s   = word_done_s & pending_s;
  assign load_word_s = word_done_s & ~pending_s;
  assign len_full_s  = {rx_shift_r, len_r[23:0]};
  assign word_s      = {rx_shift_r, asm_r};
  assign sum_match_s = (rx_shift_r == sum_r);

  // Frame-level next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (frame_err_s)                              state_s = ST_ERR;
        else if (byte_valid_s && rx_shift_r == 8'hA5) state_s = ST_LEN;
        else                                          state_s = ST_HDR;
      end
      ST_LEN: begin
        if (frame_err_s) begin
          state_s = ST_ERR;
        end else if (byte_valid_s && byte_cnt_r == 2'd3) begin
          if (len_full_s > MAX_LEN)      state_s = ST_ERR;
          else if (len_full_s == 32'd0)  state_s = ST_CSUM;
          else                           state_s = ST_DATA;
        end else begin
          state_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (frame_err_s || overrun_s)                          state_s = ST_ERR;
        else if (word_done_s && (word_idx_r + 32'd1 == len_r)) state_s = ST_CSUM;
        else                                                   state_s = ST_DATA;
      end
      ST_CSUM: begin
        // release only once the last write has actually retired
        if (frame_err_s) begin
          state_s = ST_ERR;
        end else if (byte_valid_s) begin
          if (!sum_match_s)    state_s = ST_ERR;
          else if (!pending_s) state_s = ST_DONE;
          else                 state_s = ST_CSUM;
        end else if (csum_ok_r && !pending_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_DONE: state_s = ST_DONE;
      ST_ERR:  state_s = ST_ERR;
      default: state_s = ST_ERR;
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_HDR;
    else       state_r <= state_s;
  end

  // Length capture, word assembly and running checksum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      asm_r      <= 24'd0;
      word_idx_r <= 32'd0;
      sum_r      <= 8'd0;
      csum_ok_r  <= 1'b0;
    end else if (byte_valid_s) begin
      case (state_r)
        ST_LEN: begin
          case (byte_cnt_r)
            2'd0:    len_r[7:0]   <= rx_shift_r;
            2'd1:    len_r[15:8]  <= rx_shift_r;
            2'd2:    len_r[23:16] <= rx_shift_r;
            default: len_r[31:24] <= rx_shift_r;
          endcase
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
        ST_DATA: begin
          case (byte_cnt_r)
            2'd0:    asm_r[7:0]   <= rx_shift_r;
            2'd1:    asm_r[15:8]  <= rx_shift_r;
            2'd2:    asm_r[23:16] <= rx_shift_r;
            default: asm_r        <= asm_r;
          endcase
          sum_r      <= csum_add(sum_r, rx_shift_r);
          byte_cnt_r <= byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) word_idx_r <= word_idx_r + 32'd1;
        end
        ST_CSUM: csum_ok_r <= sum_match_s;
        default: csum_ok_r <= csum_ok_r;
      endcase
    end
  end

  // Avalon write holding register and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_write_r     <= 1'b0;
      avm_address_r   <= BASE_ADDR;
      avm_writedata_r <= 32'd0;
    end else if (load_word_s) begin
      avm_write_r     <= 1'b1;
      avm_address_r   <= BASE_ADDR + (word_idx_r << 2);
      avm_writedata_r <= word_s;
    end else if (avm_write_r && !avm.avm_waitrequest) begin
      avm_write_r <= 1'b0;
    end
  end

  // Registered status outputs; both terminal states are sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold_r  <= 1'b1;
      boot_done_r <= 1'b0;
      boot_err_r  <= 1'b0;
    end else begin
      cpu_hold_r  <= (state_r != ST_DONE);
      boot_done_r <= (state_r == ST_DONE);
      boot_err_r  <= (state_r == ST_ERR);
    end
  end

  assign avm.avm_write      = avm_write_r;
  assign avm.avm_address    = avm_address_r;
  assign avm.avm_writedata  = avm_writedata_r;
  assign avm.avm_byteenable = 4'hF;
  assign cpu_hold           = cpu_hold_r;
  assign boot_done          = boot_done_r;
  assign boot_err           = boot_err_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected Avalon writes are queued as frames are sent
// and popped when the DUT retires each write.
module tb_uart_boot_loader;
  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MAXW = 4;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_hold, boot_done, boot_err;

  uart_boot_loader_if avm_bus ();

  uart_boot_loader #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE),
    .MAX_WORDS    (MAXW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .avm       (avm_bus),
    .cpu_hold  (cpu_hold),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;
  int unsigned extra_wr  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: stalled writes must match the queue head, retired writes pop it
  always @(negedge clk) begin
    if (!reset && avm_bus.avm_write) begin
      if (exp_q.size() == 0) begin
        extra_wr++;
      end else if (avm_bus.avm_waitrequest) begin
        check_val("stall_addr", avm_bus.avm_address, exp_q[0][63:32]);
        check_val("stall_data", avm_bus.avm_writedata, exp_q[0][31:0]);
      end else begin
        exp_e = exp_q.pop_front();
        check_val("wr_addr", avm_bus.avm_address, exp_e[63:32]);
        check_val("wr_data", avm_bus.avm_writedata, exp_e[31:0]);
        check_val("wr_be", 32'(avm_bus.avm_byteenable), 32'h0000_000F);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) tick();
  endtask

  task automatic send_byte_stop(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_stop(b, 1'b1);
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit expect_wr);
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
    if (expect_wr) exp_q.push_back({addr, w});
    send_byte(w[31:24]);
  endtask

  task automatic send_image(input logic [7:0] csum);
    send_byte(8'hA5);
    send_len(32'd2);
    send_word(32'h1234_5678, BASE, 1'b1);
    send_word(32'hDEAD_BEEF, BASE + 32'd4, 1'b1);
    send_byte(csum);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
    check_val({tag, "_done"}, 32'(boot_done), 32'(done));
    check_val({tag, "_err"},  32'(boot_err),  32'(err));
    check_val({tag, "_hold"}, 32'(cpu_hold),  32'(hold));
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_extra"},   32'(extra_wr),     32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_write"}, 32'(avm_bus.avm_write), 32'd0);
    check_val({tag, "_addr"},  avm_bus.avm_address,    BASE);
    check_val({tag, "_data"},  avm_bus.avm_writedata,  32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    avm_bus.avm_waitrequest = 1'b0;
    wait_cycles(3);
    exp_q.delete();
    extra_wr = 0;
    reset = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    avm_bus.avm_waitrequest = 1'b0;
    do_reset();
    check_reset_vals("rst");

    // good two-word image, then a malformed byte after DONE must be ignored
    send_image(8'h4C);
    wait_cycles(10);
    check_status("good", 1'b1, 1'b0, 1'b0);
    check_drained("good");
    send_byte_stop(8'h11, 1'b0);
    wait_cycles(5);
    check_status("after_done", 1'b1, 1'b0, 1'b0);

    // checksum mismatch: both writes still happen
    do_reset();
    send_image(8'h4D);
    wait_cycles(10);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    check_drained("bad_csum");

    // leading junk and a zero-length image
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_len(32'd0);
    send_byte(8'h00);
    wait_cycles(10);
    check_status("zero_len", 1'b1, 1'b0, 1'b0);
    check_drained("zero_len");

    // length above MAX_WORDS
    do_reset();
    send_byte(8'hA5);
    send_len(32'd5);
    wait_cycles(5);
    check_status("too_long", 1'b0, 1'b1, 1'b1);
    check_drained("too_long");

    // long stall on word 0, then the frame completes normally
    do_reset();
    send_byte(8'hA5);
    send_len(32'd2);
    avm_bus.avm_waitrequest = 1'b1;
    send_word(32'h1234_5678, BASE, 1'b1);
    wait_cycles(100);
    check_val("stall_write", 32'(avm_bus.avm_write), 32'd1);
    avm_bus.avm_waitrequest = 1'b0;
    send_word(32'hDEAD_BEEF, BASE + 32'd4, 1'b1);
    send_byte(8'h4C);
    wait_cycles(10);
    check_status("stall", 1'b1, 1'b0, 1'b0);
    check_drained("stall");

    // overrun: word 1 completes while word 0 is still stalled
    do_reset();
    send_byte(8'hA5);
    send_len(32'd2);
    avm_bus.avm_waitrequest = 1'b1;
    send_word(32'h1234_5678, BASE, 1'b1);
    send_word(32'hDEAD_BEEF, BASE + 32'd4, 1'b0);
    wait_cycles(5);
    check_status("overrun", 1'b0, 1'b1, 1'b1);
    check_val("overrun_held", 32'(avm_bus.avm_write), 32'd1);
    avm_bus.avm_waitrequest = 1'b0;
    wait_cycles(5);
    check_val("overrun_drop", 32'(avm_bus.avm_write), 32'd0);
    check_drained("overrun");

    // framing error on a data byte
    do_reset();
    send_byte(8'hA5);
    send_len(32'd1);
    send_byte_stop(8'h11, 1'b0);
    wait_cycles(5);
    check_status("framing", 1'b0, 1'b1, 1'b1);

    // one-cycle low glitch between length bytes must not become a byte
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    wait_cycles(10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_cycles(10);
    check_status("glitch", 1'b1, 1'b0, 1'b0);
    check_drained("glitch");

    // reset while a write is stalled, then a clean reload
    do_reset();
    send_byte(8'hA5);
    send_len(32'd2);
    avm_bus.avm_waitrequest = 1'b1;
    send_word(32'h1234_5678, BASE, 1'b1);
    send_byte(8'hAA);
    wait_cycles(2);
    check_val("mid_write", 32'(avm_bus.avm_write), 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_drop", 32'(avm_bus.avm_write), 32'd0);
    do_reset();
    check_reset_vals("mid_rst");
    send_image(8'h4C);
    wait_cycles(10);
    check_status("reload", 1'b1, 1'b0, 1'b0);
    check_drained("reload");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
